// File: rtl/id_ex_operand_reg.sv
// ID->EX operand register: resolves rs1/rs2 through the EX/MEM bypass, muxes
// the ALU, AGU and CSR operands from the decoded select codes, and registers
// them behind a valid/ready handshake with stall, flush and load-use interlock.
module id_ex_operand_reg #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [RA_W-1:0] in_rs1_addr,
  input  logic [RA_W-1:0] in_rs2_addr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_zimm,
  input  logic [RA_W-1:0] in_rd,
  input  logic [1:0]      in_alu_a_sel,
  input  logic [1:0]      in_alu_b_sel,
  input  logic [1:0]      in_agu_sel,
  input  logic [1:0]      in_csr_sel,
  input  logic            ex_fwd_valid,
  input  logic            ex_fwd_is_load,
  input  logic [RA_W-1:0] ex_fwd_rd,
  input  logic [XLEN-1:0] ex_fwd_data,
  input  logic            mem_fwd_valid,
  input  logic [RA_W-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op_a,
  output logic [XLEN-1:0] out_op_b,
  output logic [XLEN-1:0] out_agu_base,
  output logic [XLEN-1:0] out_agu_off,
  output logic [XLEN-1:0] out_csr_src,
  output logic [XLEN-1:0] out_store_data,
  output logic [RA_W-1:0] out_rd,
  output logic [XLEN-1:0] out_pc
);

  localparam logic [1:0] SEL_NOP = 2'd0;
  localparam logic [1:0] SEL_RS  = 2'd1;
  localparam logic [1:0] SEL_ALT = 2'd2;
  localparam logic [1:0] SEL_K   = 2'd3;

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic            rs1_used;
  logic            lu_stall;
  logic            accept;
  logic [XLEN-1:0] op_a_d;
  logic [XLEN-1:0] op_b_d;
  logic [XLEN-1:0] agu_base_d;
  logic [XLEN-1:0] csr_src_d;

  // Bypass rs1: x0 reads zero, then EX result, then MEM result, then regfile
  always_comb begin
    rs1_fwd = in_rs1_data;
    if (in_rs1_addr == '0) begin
      rs1_fwd = '0;
    end else if (ex_fwd_valid && (ex_fwd_rd == in_rs1_addr)) begin
      rs1_fwd = ex_fwd_data;
    end else if (mem_fwd_valid && (mem_fwd_rd == in_rs1_addr)) begin
      rs1_fwd = mem_fwd_data;
    end
  end

  // Bypass rs2 with the same priority; rs2 also feeds the store data path
  always_comb begin
    rs2_fwd = in_rs2_data;
    if (in_rs2_addr == '0) begin
      rs2_fwd = '0;
    end else if (ex_fwd_valid && (ex_fwd_rd == in_rs2_addr)) begin
      rs2_fwd = ex_fwd_data;
    end else if (mem_fwd_valid && (mem_fwd_rd == in_rs2_addr)) begin
      rs2_fwd = mem_fwd_data;
    end
  end

  // Load-use interlock: a load in EX cannot bypass, so hold decode one cycle
  always_comb begin
    rs1_used = (in_alu_a_sel == SEL_RS) || (in_agu_sel == SEL_RS) ||
               (in_csr_sel == SEL_RS);
    lu_stall = ex_fwd_valid && ex_fwd_is_load && (ex_fwd_rd != '0) &&
               ((rs1_used && (ex_fwd_rd == in_rs1_addr)) ||
                (ex_fwd_rd == in_rs2_addr));
    in_ready = (!out_valid || out_ready) && !lu_stall && !flush;
    accept   = in_valid && in_ready;
  end

  // Operand muxes; nop and undefined select codes produce zero
  always_comb begin
    op_a_d     = '0;
    op_b_d     = '0;
    agu_base_d = '0;
    csr_src_d  = '0;
    case (in_alu_a_sel)
      SEL_RS:  op_a_d = rs1_fwd;
      SEL_ALT: op_a_d = in_pc;
      default: op_a_d = '0;
    endcase
    case (in_alu_b_sel)
      SEL_RS:  op_b_d = rs2_fwd;
      SEL_ALT: op_b_d = in_imm;
      SEL_K:   op_b_d = XLEN'(4);
      default: op_b_d = '0;
    endcase
    case (in_agu_sel)
      SEL_RS:  agu_base_d = rs1_fwd;
      SEL_ALT: agu_base_d = in_pc;
      default: agu_base_d = '0;
    endcase
    case (in_csr_sel)
      SEL_RS:  csr_src_d = rs1_fwd;
      SEL_ALT: csr_src_d = {{(XLEN-5){1'b0}}, in_zimm};
      default: csr_src_d = '0;
    endcase
  end

  // Pipeline register: reset, then flush, then accept, then drain to a bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_op_a       <= '0;
      out_op_b       <= '0;
      out_agu_base   <= '0;
      out_agu_off    <= '0;
      out_csr_src    <= '0;
      out_store_data <= '0;
      out_rd         <= '0;
      out_pc         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      out_op_a       <= op_a_d;
      out_op_b       <= op_b_d;
      out_agu_base   <= agu_base_d;
      out_agu_off    <= in_imm;
      out_csr_src    <= csr_src_d;
      out_store_data <= rs2_fwd;
      out_rd         <= in_rd;
      out_pc         <= in_pc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/id_ex_operand_reg.md
Name: id_ex_operand_reg

Overview:
- ID→EX pipeline register that consumes the decoded ALU, AGU and CSR source-select codes.
- Resolves register operands through EX/MEM bypass and muxes the final ALU A/B, AGU base and CSR write-source operands.
- Registers the muxed operands behind a valid/ready handshake with stall, flush and load-use interlock.
- Sits between the decode-stage select units and the ALU/AGU/CSR execute units.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  kill in-flight/incoming instruction (branch/trap redirect).
- in_valid  in  1  decode holds an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_pc  in  XLEN  instruction PC.
- in_rs1_addr, in_rs2_addr  in  RA_W  source register indices.
- in_rs1_data, in_rs2_data  in  XLEN  regfile read data.
- in_imm  in  XLEN  sign-extended immediate.
- in_zimm  in  5  CSR immediate (rs1 field).
- in_rd  in  RA_W  destination index.
- in_alu_a_sel  in  2  0=nop, 1=rs1, 2=pc, 3=zero.
- in_alu_b_sel  in  2  0=nop, 1=rs2, 2=imm, 3=const 4.
- in_agu_sel  in  2  0=nop, 1=rs1, 2=pc.
- in_csr_sel  in  2  0=nop, 1=rs1, 2=zimm.
- ex_fwd_valid  in  1  EX result valid for bypass.
- ex_fwd_is_load  in  1  EX instruction is a load (data not yet available).
- ex_fwd_rd  in  RA_W  EX destination.
- ex_fwd_data  in  XLEN  EX result.
- mem_fwd_valid  in  1  MEM result valid.
- mem_fwd_rd  in  RA_W  MEM destination.
- mem_fwd_data  in  XLEN  MEM result.
- out_valid  out  1  registered instruction valid.
- out_ready  in  1  execute accepts.
- out_op_a, out_op_b  out  XLEN  ALU operands.
- out_agu_base  out  XLEN  AGU base.
- out_agu_off  out  XLEN  AGU offset (= imm).
- out_csr_src  out  XLEN  CSR write source.
- out_store_data  out  XLEN  forwarded rs2 for stores.
- out_rd  out  RA_W  destination.
- out_pc  out  XLEN  PC passthrough.

Behaviour:
- Reset (rst_n=0 at posedge): out_valid=0; all data outputs=0. Reset has priority over flush and accept. Reset mid-stall discards the held instruction.
- Bypass, combinational per source (rs1, rs2):
  - Source index 0 → 0.
  - Else ex_fwd_valid && ex_fwd_rd==idx → ex_fwd_data.
  - Else mem_fwd_valid && mem_fwd_rd==idx → mem_fwd_data.
  - Else regfile data. EX wins over MEM.
- Source used:
  - rs1 is used when in_alu_a_sel==1, in_agu_sel==1 or in_csr_sel==1.
  - rs2 is used when in_alu_b_sel==1; rs2 is always treated as used for store data.
- Load-use interlock: lu_stall = ex_fwd_valid && ex_fwd_is_load && ex_fwd_rd!=0 && ex_fwd_rd matches a used rs1 or any nonzero rs2.
- in_ready = (!out_valid || out_ready) && !lu_stall && !flush.
- Operand muxes:
  - A: rs1fwd / pc / 0.
  - B: rs2fwd / imm / 32'd4.
  - AGU: rs1fwd / pc.
  - CSR: rs1fwd / {27'b0,zimm}.
  - Select 0 or an undefined code → 0.
- Register update at posedge:
  - flush → out_valid=0.
  - Else accept (in_valid && in_ready) → load all outputs, out_valid=1.
  - Else if out_ready → out_valid=0 (bubble, data held).
  - Else hold everything unchanged.
- Stall (out_valid && !out_ready): outputs stable bit-for-bit. Operands are captured at accept; later bypass changes are not re-applied to held data.
- Latency: one cycle accept→out_valid. Back-to-back throughput one per cycle when out_ready=1.
- lu_stall inserts exactly one bubble: out_valid drops to 0 if the prior instruction drains. The instruction is accepted the cycle EX no longer reports the load.
- flush together with in_valid: instruction dropped, in_ready=0.

Test Plan:
- Reset: rst_n=0 two cycles with in_valid=1 → out_valid=0, out_op_a=0. Release → first accept next cycle.
- ADDI x5,x1,7: rs1=x1, rs1_data=0x10, imm=7, A=1, B=2 → next cycle out_op_a=0x10, out_op_b=7, out_valid=1.
- Bypass priority: rs1=x3, ex_fwd rd=3 data=0xAA, mem_fwd rd=3 data=0xBB → out_op_a=0xAA. Repeat with rd=0 everywhere → out_op_a=0.
- JAL: pc=0x8000_0010, A=2, B=3, AGU=2, imm=0x20 → out_op_a=0x80000010, out_op_b=4, out_agu_base=0x80000010, out_agu_off=0x20.
- Load-use: ex_fwd_is_load=1, ex_fwd_rd=6, incoming rs2=x6 → in_ready=0 one cycle and out_valid=0 bubble. Next cycle the MEM bypass supplies the data.
- Stall then flush: out_ready=0 for 3 cycles → outputs constant. flush=1 → out_valid=0 next cycle while in_valid=1 is dropped.
